// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core: one round per accepted schedule word W_t.
// Holds the working variables a..h and the chaining hash H0..H7; digest = {H0..H7}.
module sha256_round_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         chain,
    input  logic         w_valid,
    input  logic [31:0]  w_data,
    output logic         w_ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

    localparam logic [31:0] InitHash [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] RoundK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_e      state_q;
    logic [5:0]  t_q;
    logic [31:0] wv_q   [8];  // working variables, index 0 = a ... 7 = h
    logic [31:0] hash_q [8];
    logic        busy_q;
    logic        w_ready_q;
    logic        done_q;

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + RoundK[t_q]
           + w_data;
        t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            t_q       <= '0;
            busy_q    <= 1'b0;
            w_ready_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                wv_q[i]   <= '0;
                hash_q[i] <= InitHash[i];
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int i = 0; i < 8; i++) begin
                            if (chain) begin
                                wv_q[i] <= hash_q[i];
                            end else begin
                                wv_q[i]   <= InitHash[i];
                                hash_q[i] <= InitHash[i];
                            end
                        end
                        t_q       <= '0;
                        busy_q    <= 1'b1;
                        w_ready_q <= 1'b1;
                        state_q   <= StRound;
                    end
                end
                StRound: begin
                    if (w_valid && w_ready_q) begin
                        wv_q[7] <= wv_q[6];
                        wv_q[6] <= wv_q[5];
                        wv_q[5] <= wv_q[4];
                        wv_q[4] <= wv_q[3] + t1;
                        wv_q[3] <= wv_q[2];
                        wv_q[2] <= wv_q[1];
                        wv_q[1] <= wv_q[0];
                        wv_q[0] <= t1 + t2;
                        // t wraps to 0 on the last round, ready for the next block
                        t_q     <= t_q + 6'd1;
                        if (t_q == 6'd63) begin
                            w_ready_q <= 1'b0;
                            state_q   <= StFinal;
                        end
                    end
                end
                StFinal: begin
                    for (int i = 0; i < 8; i++) begin
                        hash_q[i] <= hash_q[i] + wv_q[i];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign w_ready = w_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign digest  = {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                      hash_q[4], hash_q[5], hash_q[6], hash_q[7]};

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known SHA-256 vectors, stalls, back-to-back
// blocks, protocol abuse and mid-block reset.
module tb_sha256_round_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         chain;
    logic         w_valid;
    logic [31:0]  w_data;
    logic         w_ready;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    always #5 clk = ~clk;

    sha256_round_engine dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .chain   (chain),
        .w_valid (w_valid),
        .w_data  (w_data),
        .w_ready (w_ready),
        .busy    (busy),
        .done    (done),
        .digest  (digest)
    );

    localparam logic [255:0] IvDigest =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] EmptyDigest =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] AbcDigest =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TwoBlkDigest =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] msg   [16];
    logic [31:0] sched [64];

    // Results of the most recent run_block
    int   r_lat;
    int   r_stalls;
    logic r_busy_start;
    logic r_ready_start;
    logic r_busy_done;
    logic r_timeout;

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Stands in for the upstream message-schedule stage.
    task automatic expand();
        for (int t = 0; t < 16; t++) sched[t] = msg[t];
        for (int t = 16; t < 64; t++)
            sched[t] = small_sigma1(sched[t-2]) + sched[t-7] + small_sigma0(sched[t-15])
                     + sched[t-16];
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    // Entered and left at #1 after a rising edge. Latency counts edges after the start edge
    // until done is seen; 65 edges means done sits in the 66th cycle counting the start cycle.
    task automatic run_block(input logic chain_in, input bit rand_stall, input bit abuse,
                             input int abort_at);
        int idx;
        int cyc;
        bit rdy;
        bit vld;
        bit pulsed;
        expand();
        start   = 1'b1;
        chain   = chain_in;
        w_valid = abuse;
        w_data  = 32'hdeadbeef;
        @(posedge clk); #1;
        start         = 1'b0;
        chain         = 1'b0;
        r_busy_start  = busy;
        r_ready_start = w_ready;
        idx = 0; cyc = 0; pulsed = 0;
        r_stalls  = 0;
        r_timeout = 1'b0;
        while (done !== 1'b1) begin
            if (cyc > 400) begin
                r_timeout = 1'b1;
                break;
            end
            rdy = (w_ready === 1'b1);
            vld = (idx < 64) && !(rand_stall && ($urandom_range(0, 2) == 0));
            if (rdy && !vld && idx < 64) r_stalls++;
            w_valid = vld;
            w_data  = vld ? sched[idx] : $urandom;
            if (abuse && idx == 10 && !pulsed) begin
                start  = 1'b1;
                chain  = 1'b1;
                pulsed = 1;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst     = 1'b0;
                w_valid = 1'b0;
                r_lat   = -1;
                return;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            chain = 1'b0;
            if (rdy && vld) idx++;
        end
        w_valid     = 1'b0;
        r_lat       = cyc;
        r_busy_done = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; chain = 1'b0; w_valid = 1'b0; w_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total_cnt++;
        if (digest !== IvDigest) $display("FAIL reset_digest: got %h expected %h", digest, IvDigest);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (w_ready !== 1'b0) $display("FAIL reset_w_ready: got %b expected 0", w_ready);
        else pass_cnt++;
    endtask

    task automatic test_empty();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0] = 32'h80000000;
        run_block(1'b0, 0, 0, -1);
        total_cnt++;
        if (r_timeout !== 1'b0) $display("FAIL empty_timeout: got %b expected 0", r_timeout);
        else pass_cnt++;
        total_cnt++;
        if (digest !== EmptyDigest)
            $display("FAIL empty_digest: got %h expected %h", digest, EmptyDigest);
        else pass_cnt++;
        total_cnt++;
        if (r_lat != 65) $display("FAIL empty_latency: got %0d expected 65", r_lat);
        else pass_cnt++;
        total_cnt++;
        if (r_busy_start !== 1'b1) $display("FAIL empty_busy_rise: got %b expected 1", r_busy_start);
        else pass_cnt++;
        total_cnt++;
        if (r_ready_start !== 1'b1)
            $display("FAIL empty_w_ready_round: got %b expected 1", r_ready_start);
        else pass_cnt++;
        total_cnt++;
        if (r_busy_done !== 1'b0) $display("FAIL empty_busy_fall: got %b expected 0", r_busy_done);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL empty_done_pulse: got %b expected 0", done);
        else pass_cnt++;
        total_cnt++;
        if (digest !== EmptyDigest)
            $display("FAIL empty_digest_hold: got %h expected %h", digest, EmptyDigest);
        else pass_cnt++;
    endtask

    task automatic test_abc_stalls();
        load_abc();
        run_block(1'b0, 1, 0, -1);
        total_cnt++;
        if (digest !== AbcDigest) $display("FAIL abc_digest: got %h expected %h", digest, AbcDigest);
        else pass_cnt++;
        total_cnt++;
        if (r_lat != 65 + r_stalls)
            $display("FAIL abc_latency: got %0d expected %0d", r_lat, 65 + r_stalls);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        run_block(1'b0, 0, 0, -1);
        total_cnt++;
        if (r_timeout !== 1'b0) $display("FAIL two_blk1_timeout: got %b expected 0", r_timeout);
        else pass_cnt++;
        // Second block starts in the done cycle of the first.
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[15] = 32'h000001c0;
        run_block(1'b1, 0, 0, -1);
        total_cnt++;
        if (digest !== TwoBlkDigest)
            $display("FAIL two_blk_digest: got %h expected %h", digest, TwoBlkDigest);
        else pass_cnt++;
        total_cnt++;
        if (r_lat != 65) $display("FAIL two_blk2_latency: got %0d expected 65", r_lat);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_abuse();
        int bad;
        bad = 0;
        w_data = 32'hcafef00d;
        for (int i = 0; i < 3; i++) begin
            w_valid = 1'b1;
            if (w_ready !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        total_cnt++;
        if (bad != 0) $display("FAIL idle_w_ready: got %0d busy/ready cycles expected 0", bad);
        else pass_cnt++;
        load_abc();
        run_block(1'b0, 0, 1, -1);
        total_cnt++;
        if (digest !== AbcDigest)
            $display("FAIL abuse_digest: got %h expected %h", digest, AbcDigest);
        else pass_cnt++;
        total_cnt++;
        if (r_lat != 65) $display("FAIL abuse_latency: got %0d expected 65", r_lat);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        load_abc();
        run_block(1'b0, 0, 0, 30);
        total_cnt++;
        if (digest !== IvDigest)
            $display("FAIL midrst_digest: got %h expected %h", digest, IvDigest);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (w_ready !== 1'b0) $display("FAIL midrst_w_ready: got %b expected 0", w_ready);
        else pass_cnt++;
        // A couple of idle cycles: no stray completion from the discarded block.
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_idle: got done=%b busy=%b expected done=0 busy=0", done, busy);
        else pass_cnt++;
        run_block(1'b0, 0, 0, -1);
        total_cnt++;
        if (digest !== AbcDigest)
            $display("FAIL midrst_abc_digest: got %h expected %h", digest, AbcDigest);
        else pass_cnt++;
        total_cnt++;
        if (r_lat != 65) $display("FAIL midrst_abc_latency: got %0d expected 65", r_lat);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc_stalls();
        test_back_to_back();
        test_abuse();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
